// File: rtl/spi_receive_con.sv
// spi_receive_con: receive side of the inter-board pixel link.
// Turns the multi-line SPI link (dclk/cipo/cs/tlast) into parallel pixels in
// the clk_in domain. Each pixel is tagged with its hcount/vcount position.
// Ports:
//   clk_in, rst_in   system clock, synchronous active-high reset
//   chip_data_in     link data lines, MSB group first
//   chip_clk_in      link data clock (sampled on its rising edge)
//   chip_sel_in      link chip select, active low
//   final_pixel_in   link tlast, high during last word of frame
//   data_out         received pixel (held between strobes)
//   data_valid_out   1-cycle strobe qualifying data_out/hcount_out/vcount_out
//   hcount_out       column of data_out
//   vcount_out       row of data_out
//   frame_done_out   1-cycle strobe alongside the valid of the tlast word
//   error_out        1-cycle strobe when cs rose mid-word
module spi_receive_con #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LINES       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HRES        = 640,
  parameter int unsigned VRES        = 360
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [LINES-1:0]          chip_data_in,
  input  logic                      chip_clk_in,
  input  logic                      chip_sel_in,
  input  logic                      final_pixel_in,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid_out,
  output logic [$clog2(HRES)-1:0]   hcount_out,
  output logic [$clog2(VRES)-1:0]   vcount_out,
  output logic                      frame_done_out,
  output logic                      error_out
);

  localparam int unsigned BEATS = DATA_WIDTH / LINES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned HW    = $clog2(HRES);
  localparam int unsigned VW    = $clog2(VRES);
  // Synchroniser payload: {tlast, cs, dclk, data}
  localparam int unsigned IW    = LINES + 3;

  // Elaboration-time parameter sanity
  if (DATA_WIDTH % LINES != 0) begin : g_bad_width
    $error("spi_receive_con: DATA_WIDTH must be a multiple of LINES");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_receive_con: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_RECV      = 2'd2
  } state_t;

  state_t                          r_state;
  logic [SYNC_STAGES-1:0][IW-1:0]  r_sync;
  logic                            r_dclk_prev;
  logic [DATA_WIDTH-1:0]           r_sr;
  logic [BW-1:0]                   r_beat;
  logic [HW-1:0]                   r_h;
  logic [VW-1:0]                   r_v;

  logic [IW-1:0]                   w_pins;
  logic [IW-1:0]                   w_synced;
  logic [LINES-1:0]                w_data;
  logic                            w_dclk;
  logic                            w_cs;
  logic                            w_tlast;
  logic                            w_rise;
  logic [DATA_WIDTH-1:0]           w_word;

  // All link inputs share one chain so they stay cycle-aligned
  assign w_pins   = {final_pixel_in, chip_sel_in, chip_clk_in, chip_data_in};
  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_data   = w_synced[LINES-1:0];
  assign w_dclk   = w_synced[LINES];
  assign w_cs     = w_synced[LINES+1];
  assign w_tlast  = w_synced[LINES+2];
  assign w_rise   = w_dclk & ~r_dclk_prev;
  // Shift register with the current beat appended; upper bits fall off
  assign w_word   = DATA_WIDTH'({r_sr, w_data});

  // Synchronisers, receive FSM, pixel counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= S_WAIT_IDLE;
      r_sync         <= '0;
      r_dclk_prev    <= 1'b0;
      r_sr           <= '0;
      r_beat         <= '0;
      r_h            <= '0;
      r_v            <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      frame_done_out <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_dclk_prev    <= w_dclk;
      data_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      error_out      <= 1'b0;

      case (r_state)
        // Wait for an idle link so a transfer interrupted by reset is dropped
        S_WAIT_IDLE: begin
          if (w_cs) r_state <= S_IDLE;
        end

        S_IDLE: begin
          if (!w_cs) begin
            r_state <= S_RECV;
            r_beat  <= '0;
            r_sr    <= '0;
          end
        end

        S_RECV: begin
          // cs deassertion has priority over a coincident dclk edge
          if (w_cs) begin
            if (r_beat != '0) error_out <= 1'b1;
            r_beat  <= '0;
            r_sr    <= '0;
            r_state <= S_IDLE;
          end else if (w_rise) begin
            r_sr <= w_word;
            if (r_beat == BW'(BEATS - 1)) begin
              r_beat         <= '0;
              data_out       <= w_word;
              data_valid_out <= 1'b1;
              hcount_out     <= r_h;
              vcount_out     <= r_v;
              frame_done_out <= w_tlast;
              // r_h/r_v hold the position of the next pixel
              if (w_tlast) begin
                r_h <= '0;
                r_v <= '0;
              end else if (r_h == HW'(HRES - 1)) begin
                r_h <= '0;
                r_v <= (r_v == VW'(VRES - 1)) ? '0 : VW'(r_v + 1'b1);
              end else begin
                r_h <= HW'(r_h + 1'b1);
              end
            end else begin
              r_beat <= BW'(r_beat + 1'b1);
            end
          end
        end

        default: r_state <= S_WAIT_IDLE;
      endcase
    end
  end

endmodule
